// File: rtl/io_bridge_pkg.sv
// Shared types for the CPU-to-IO_BUS bridge: FSM encoding, MMIO window default,
// and the layout of a posted-write buffer entry.
package io_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  localparam logic [15:0] MMIO_HI_DEFAULT = 16'hFFFF;
  localparam int          WBUF_W          = 48;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wbuf_entry_t;

  function automatic logic in_window(input logic [31:0] addr, input logic [15:0] hi);
    return addr[31:16] == hi;
  endfunction

endpackage

// File: rtl/io_wbuf_fifo.sv
// Synchronous FIFO for posted stores. Pointers carry an extra wrap bit so full
// and empty are distinguished without a separate occupancy counter.
module io_wbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/cpu_io_bridge.sv
// MMIO bridge from the CPU data-memory stage to the PDU IO_BUS: posted stores,
// in-order blocking loads. Define IO_STAT_EN to build the retired store/load counters.
module cpu_io_bridge
  import io_bridge_pkg::*;
#(
  parameter int          WBUF_DEPTH = 4,
  parameter logic [15:0] MMIO_HI    = MMIO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [15:0] io_addr,
  output logic [31:0] io_dout,
  output logic        io_we,
  output logic        io_rd,
  input  logic [31:0] io_din,
  output logic [15:0] stat_wr,
  output logic [15:0] stat_rd
);

  // Handshake: a request transfers on any cycle where req_valid && req_ready;
  // the CPU holds req_* stable until then. rsp_valid is a single-cycle pulse.

  state_t      state;
  state_t      state_nxt;
  logic        in_win;
  logic        accept;
  logic        ld_accept;
  logic        st_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  wbuf_entry_t push_entry;
  wbuf_entry_t head;

  assign in_win    = in_window(req_addr, MMIO_HI);
  assign accept    = req_valid && req_ready;
  assign ld_accept = accept && !req_we;
  assign st_push   = accept && req_we && in_win;

  assign push_entry.addr = req_addr[15:0];
  assign push_entry.data = req_wdata;

  // Loads only enter once the buffer has drained, so no store-to-load forwarding is needed.
  always_comb begin
    req_ready = 1'b0;
    if (!rst) begin
      if (req_we) req_ready = !fifo_full;
      else        req_ready = fifo_empty && (state == ST_IDLE);
    end
  end

  io_wbuf_fifo #(
    .DEPTH (WBUF_DEPTH),
    .W     (WBUF_W)
  ) u_wbuf (
    .clk   (clk),
    .rst   (rst),
    .push  (st_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        fifo_pop = !fifo_empty;
        // Out-of-window loads skip the bus and answer zero on the next cycle.
        if (ld_accept) state_nxt = in_win ? ST_RD : ST_RSP;
      end
      ST_RD:   state_nxt = ST_RSP;
      ST_RSP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign io_rd     = (state == ST_RD);
  assign rsp_valid = (state == ST_RSP);

  always_ff @(posedge clk) begin
    if (rst) begin
      io_we     <= 1'b0;
      io_addr   <= '0;
      io_dout   <= '0;
      rsp_rdata <= '0;
    end else begin
      io_we <= fifo_pop;
      if (fifo_pop) begin
        io_addr <= head.addr;
        io_dout <= head.data;
      end else if (ld_accept && in_win) begin
        io_addr <= req_addr[15:0];
      end
      if (state == ST_RD)             rsp_rdata <= io_din;
      else if (ld_accept && !in_win)  rsp_rdata <= '0;
    end
  end

`ifdef IO_STAT_EN
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (io_we) wr_cnt <= wr_cnt + 16'd1;
      if (io_rd) rd_cnt <= rd_cnt + 16'd1;
    end
  end

  assign stat_wr = wr_cnt;
  assign stat_rd = rd_cnt;
`else
  assign stat_wr = 16'h0;
  assign stat_rd = 16'h0;
`endif

endmodule
